adc_buffer_writer: RTL and testbench

- Mirror of the DAC-side de-interleaver, for the input path: interleaves one multi-channel ADC sample into the 32-bit Xillybus read FIFO (FPGA -> host), channel 0 first.
- On adc_valid, atomically snapshots all channels, then writes them as adc_channels consecutive words.
- Whole samples are dropped, never partial, when the FIFO lacks room, so host-side channel alignment is always preserved.
- Gated by the read pipe being open and by capture_enable (normally driven from dac_open for output/input sync).

---
 rtl/adc_buffer_writer.sv | 168 ++++++++++++++++
 tb/tb_adc_buffer_writer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_buffer_writer.sv
// Interleaves one multi-channel ADC sample into a 32-bit FIFO, channel 0 first.
// Define SYNC_TAG_EN to stamp sync_tag into bits [7:0] of the channel 0 word.
module adc_buffer_writer #(
  parameter int adc_channels = 4,
  parameter int count_width  = 32
) (
  input  logic                       capture_clk,
  input  logic                       reset,
  input  logic [adc_channels*32-1:0] adc_data,
  input  logic                       adc_valid,
  input  logic                       capture_enable,
  input  logic [7:0]                 sync_tag,
  input  logic                       adc_fifo_open_bus,
  input  logic                       adc_fifo_prog_full,
  output logic                       adc_wren,
  output logic [31:0]                adc_fifo_data,
  output logic                       adc_overrun,
  output logic                       adc_overrun_sticky,
  output logic                       adc_running,
  output logic [count_width-1:0]     sample_count
);

  localparam int SW = adc_channels * 32;
  localparam int CW = $clog2(adc_channels + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT,
    S_WRITE
  } state_t;

  state_t state_q, state_d;

  (* ASYNC_REG = "TRUE" *) logic open_meta_q;
  (* ASYNC_REG = "TRUE" *) logic fifo_open_q;

  logic [SW-1:0]          shadow_q, shadow_d;
  logic [CW-1:0]          word_q, word_d;
  logic                   wren_q, wren_d;
  logic [31:0]            data_q, data_d;
  logic                   ovr_q, ovr_d;
  logic                   sticky_q, sticky_d;
  logic [count_width-1:0] count_q, count_d;

  logic [SW-1:0]          sample_w;
  logic                   take;

  always_ff @(posedge capture_clk or posedge reset) begin
    if (reset) begin
      open_meta_q <= 1'b0;
      fifo_open_q <= 1'b0;
    end else begin
      open_meta_q <= adc_fifo_open_bus;
      fifo_open_q <= open_meta_q;
    end
  end

`ifdef SYNC_TAG_EN
  always_comb begin
    sample_w = adc_data;
    sample_w[SW-32 +: 8] = sync_tag;
  end
`else
  logic unused_sync_tag;
  assign unused_sync_tag = ^sync_tag;
  assign sample_w = adc_data;
`endif

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    wren_d   = 1'b0;
    data_d   = data_q;
    ovr_d    = 1'b0;
    sticky_d = sticky_q;
    count_d  = count_q;
    take     = 1'b0;

    case (state_q)
      S_IDLE: begin
        data_d   = '0;
        sticky_d = 1'b0;
        count_d  = '0;
        if (fifo_open_q) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (capture_enable) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!capture_enable) state_d = S_ARMED;
        else take = adc_valid;
      end
      S_WRITE: begin
        if (word_q == CW'(adc_channels)) begin
          // completion edge doubles as the back-to-back accept slot
          count_d = count_q + 1'b1;
          state_d = S_WAIT;
          take    = adc_valid & capture_enable;
        end else begin
          wren_d   = 1'b1;
          data_d   = shadow_q[SW-1 -: 32];
          shadow_d = shadow_q << 32;
          word_d   = word_q + 1'b1;
          if (adc_valid) begin
            ovr_d    = 1'b1;
            sticky_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      if (adc_fifo_prog_full) begin
        ovr_d    = 1'b1;
        sticky_d = 1'b1;
      end else begin
        state_d  = S_WRITE;
        wren_d   = 1'b1;
        data_d   = sample_w[SW-1 -: 32];
        shadow_d = sample_w << 32;
        word_d   = CW'(1);
      end
    end

    // a closed pipe abandons any partial sample; reopening realigns the host
    if (!fifo_open_q) begin
      state_d  = S_IDLE;
      wren_d   = 1'b0;
      ovr_d    = 1'b0;
      data_d   = '0;
      sticky_d = 1'b0;
      count_d  = '0;
    end
  end

  always_ff @(posedge capture_clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      word_q   <= '0;
      wren_q   <= 1'b0;
      data_q   <= '0;
      ovr_q    <= 1'b0;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      wren_q   <= wren_d;
      data_q   <= data_d;
      ovr_q    <= ovr_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign adc_wren           = wren_q;
  assign adc_fifo_data      = data_q;
  assign adc_overrun        = ovr_q;
  assign adc_overrun_sticky = sticky_q;
  assign adc_running        = (state_q == S_WAIT) || (state_q == S_WRITE);
  assign sample_count       = count_q;

endmodule

// File: tb/tb_adc_buffer_writer.sv
// Self-checking bench for adc_buffer_writer against a queue-based sample model.
// Honours SYNC_TAG_EN the same way the design does.
module tb_adc_buffer_writer;

  localparam int C  = 4;
  localparam int SW = C * 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] adc_data;
  logic          adc_valid;
  logic          capture_enable;
  logic [7:0]    sync_tag;
  logic          open_bus;
  logic          prog_full;
  logic          wren;
  logic [31:0]   fdata;
  logic          ovr;
  logic          sticky;
  logic          running;
  logic [31:0]   cnt;

  adc_buffer_writer #(
    .adc_channels(C),
    .count_width (32)
  ) dut (
    .capture_clk       (clk),
    .reset             (reset),
    .adc_data          (adc_data),
    .adc_valid         (adc_valid),
    .capture_enable    (capture_enable),
    .sync_tag          (sync_tag),
    .adc_fifo_open_bus (open_bus),
    .adc_fifo_prog_full(prog_full),
    .adc_wren          (wren),
    .adc_fifo_data     (fdata),
    .adc_overrun       (ovr),
    .adc_overrun_sticky(sticky),
    .adc_running       (running),
    .sample_count      (cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: open-pipe delay line, mode, pending word queue
  bit          m_s1, m_s2;
  int          m_mode;          // 0 idle, 1 armed, 2 running
  logic [31:0] m_pend[$];
  bit          m_tail;
  int unsigned m_cnt;
  bit          m_sticky;
  logic        e_wren, e_ovr;
  logic [31:0] e_data;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_mode = 0;
    m_pend.delete(); m_tail = 0;
    m_cnt = 0; m_sticky = 0;
    e_wren = 0; e_ovr = 0; e_data = 0;
  endtask

  task automatic model_load(input logic [SW-1:0] d);
    logic [31:0] w;
    for (int i = 0; i < C; i++) begin
      w = d[(C-1-i)*32 +: 32];
`ifdef SYNC_TAG_EN
      if (i == 0) w[7:0] = sync_tag;
`endif
      if (i == 0) e_data = w;
      else m_pend.push_back(w);
    end
    e_wren = 1;
    m_tail = 1;
  endtask

  task automatic model_edge(input logic v, input logic [SW-1:0] d, input logic pf);
    bit fo;
    bit ok;
    fo = m_s2; m_s2 = m_s1; m_s1 = open_bus;
    e_wren = 0; e_ovr = 0;
    if (!fo) begin
      m_mode = 0; m_pend.delete(); m_tail = 0;
      m_cnt = 0; m_sticky = 0; e_data = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (capture_enable) m_mode = 2;
    end else if (m_pend.size() != 0) begin
      e_wren = 1;
      e_data = m_pend.pop_front();
      if (v) begin e_ovr = 1; m_sticky = 1; end
    end else begin
      ok = 1;
      if (m_tail) begin
        m_cnt++; m_tail = 0;
      end else if (!capture_enable) begin
        m_mode = 1; ok = 0;
      end
      if (ok && capture_enable && v) begin
        if (pf) begin e_ovr = 1; m_sticky = 1; end
        else model_load(d);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("wren", {31'd0, wren}, {31'd0, e_wren});
    chk("data", fdata, e_data);
    chk("overrun", {31'd0, ovr}, {31'd0, e_ovr});
    chk("sticky", {31'd0, sticky}, {31'd0, m_sticky});
    chk("running", {31'd0, running}, {31'd0, m_mode == 2});
    chk("count", cnt, m_cnt);
  endtask

  function automatic logic [SW-1:0] rnd();
    logic [SW-1:0] r;
    for (int i = 0; i < C; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // drive at a negedge, model the coming posedge, check at the next negedge
  task automatic step(input logic v, input logic [SW-1:0] d, input logic pf);
    adc_valid = v; adc_data = d; prog_full = pf;
    model_edge(v, d, pf);
    @(negedge clk);
    chk_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rnd(), 1'b0);
  endtask

  logic [SW-1:0] s_a, s_b;
  logic [31:0]   tag_exp;

  initial begin
    reset = 1; adc_valid = 0; adc_data = '0; capture_enable = 0;
    sync_tag = 0; open_bus = 0; prog_full = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk_all();
    reset = 0;

    for (int i = 0; i < 3; i++) step(1'b1, rnd(), 1'b0);
    open_bus = 1;
    for (int i = 0; i < 6; i++) step(1'($urandom % 2), rnd(), 1'b0);
    capture_enable = 1;
    idle(2);

    s_a = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    step(1'b1, s_a, 1'b0);
    idle(6);
    chk("count_first", cnt, 32'd1);

    step(1'b1, rnd(), 1'b1);
    idle(2);
    chk("sticky_set", {31'd0, sticky}, 32'd1);
    step(1'b1, rnd(), 1'b0);
    idle(6);
    chk("count_good_only", cnt, 32'd2);

    s_a = rnd(); s_b = rnd();
    step(1'b1, s_a, 1'b0); idle(1);
    step(1'b1, s_b, 1'b0); idle(5);

    step(1'b1, s_a, 1'b0); idle(C - 1);
    step(1'b1, s_b, 1'b0); idle(C + 2);

    step(1'b1, s_a, 1'b0); idle(4);
    step(1'b1, s_b, 1'b0); idle(6);

    sync_tag = 8'hA5;
    s_a = rnd();
    s_a[SW-1 -: 32] = 32'h12345600;
`ifdef SYNC_TAG_EN
    tag_exp = 32'h123456A5;
`else
    tag_exp = 32'h12345600;
`endif
    step(1'b1, s_a, 1'b0);
    chk("tag_word", fdata, tag_exp);
    idle(6);

    for (int i = 0; i < 400; i++) begin
      capture_enable = ($urandom % 16) != 0;
      sync_tag = 8'($urandom);
      step(($urandom % 3) == 0, rnd(), ($urandom % 6) == 0);
    end
    capture_enable = 1;
    idle(8);

    s_a = rnd();
    step(1'b1, s_a, 1'b0);
    idle(1);
    open_bus = 0;
    idle(3);
    chk("wren_stopped", {31'd0, wren}, 32'd0);
    chk("count_cleared", cnt, 32'd0);
    chk("sticky_cleared", {31'd0, sticky}, 32'd0);
    open_bus = 1;
    idle(4);
    s_b = rnd();
    step(1'b1, s_b, 1'b0);
    chk("reopen_ch0", fdata, e_data);
    idle(6);

    step(1'b1, rnd(), 1'b0);
    idle(1);
    #2 reset = 1;
    #1;
    chk("rst_wren", {31'd0, wren}, 32'd0);
    chk("rst_data", fdata, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_count", cnt, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 6; i++) step(1'b1, rnd(), 1'b0);
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
